mul_issue_ctrl: RTL and testbench
=================================

// Module: mul_issue_ctrl
// PURPOSE
// - RV64M multiply sequencer in the execute stage; sits directly upstream and downstream of the iterative multiplier core.
// - Conditions operands (sign/abs/32-bit), launches the core, captures the 128-bit product, applies sign fix-up and result select.
// - Presents a valid/ready handshake to the pipeline; busy stalls issue.
// PARAMETERS
// - XLEN      64   datapath width; only 64 is supported.
// - OP_W      3    width of in_op.
// PORTS
// - clk          in   1     clock; all state updates on posedge.
// - reset        in   1     synchronous, active-high reset.
// - flush        in   1     pipeline flush; kills any in-flight op.
// - in_valid     in   1     request valid.
// - in_ready     out  1     high only in IDLE and not flush.
// - in_op        in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal.
// - in_a, in_b   in   64    rs1 / rs2 values.
// - out_valid    out  1     result valid; held until out_ready.
// - out_ready    in   1     consumer accepts result.
// - out_result   out  64    final rd value.
// - mul_valid    out  1     core enable; held high for the whole operation.
// - mul_a, mul_b out  64    unsigned operands to core, stable while mul_valid.
// - mul_done     in   1     one-cycle pulse: mul_prod valid.
// - mul_prod     in   128   unsigned product from core.
// - busy         out  1     high in any state except IDLE.
// BEHAVIOUR
// - Reset: state IDLE; out_valid, mul_valid, busy = 0; out_result, mul_a, mul_b = 0; in_ready = 1.
// - FSM: IDLE -> ISSUE -> WAIT -> FIXUP -> DONE -> IDLE.
// - IDLE: on in_valid && in_ready, register op, conditioned operands and neg flag; go ISSUE.
// - ISSUE: assert mul_valid (one cycle); go WAIT.
// - WAIT: keep mul_valid = 1; on mul_done latch mul_prod, drop mul_valid next cycle; go FIXUP.
// - FIXUP: compute out_result; go DONE.
// - DONE: out_valid = 1; on out_ready return to IDLE. out_valid and out_result stay stable while out_ready = 0.
// - Illegal op (5-7): IDLE -> FIXUP directly, no core launch; result 0.
// - Latency: accept to out_valid = core latency + 3 cycles. One op in flight at a time.
// - Operand conditioning:
//   - MUL, MULHU: raw a, b; neg = 0.
//   - MULH: |a|, |b|; neg = a[63] ^ b[63].
//   - MULHSU: |a|, raw b; neg = a[63].
//   - MULW: {32'b0, a[31:0]}, {32'b0, b[31:0]}; neg = 0.
//   - |x| of 0x8000_0000_0000_0000 = 2^63, which is legal unsigned.
// - Fix-up: p = neg ? (~prod + 1) mod 2^128 : prod.
// - Result select: MUL -> p[63:0]; MULH/MULHSU/MULHU -> p[127:64]; MULW -> sext(p[31:0]).
// - Flush: in any state, next cycle is IDLE; mul_valid = 0 and out_valid = 0 that cycle. A mul_done arriving in the flush cycle is dropped.
// - Flush and in_valid in the same cycle: in_ready = 0, so nothing is accepted.
// - Flush and out_ready both high in DONE: treated as flush (the result counts as not consumed).
// - Reset mid-operation: same as flush, plus all outputs return to their reset values.
// - mul_done outside WAIT: ignored.
// CONFIGURATION
// - MUL_ZERO_BYPASS_EN defined:
//   - At accept, if the conditioned mul_a or mul_b is 0, go IDLE -> FIXUP with prod = 0; no core launch.
//   - Latency is 2 cycles.
// - MUL_ZERO_BYPASS_EN undefined: every legal op launches the core, including zero operands.
// TESTING
// - MULH a=-1, b=-1 -> out_result 0x0; MUL same operands -> 0x1.
// - MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000.
// - MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULHU a=b=-1 -> 0xFFFF_FFFF_FFFF_FFFE.
// - MULW a=0x7FFF_FFFF, b=2 -> 0xFFFF_FFFF_FFFF_FFFE. Upper operand bits 0xDEAD.. must not change the result.
// - Flush 5 cycles into WAIT:
//   - next cycle IDLE, mul_valid = 0, out_valid never asserts.
//   - MUL 3*4 issued right after -> 12.
// - out_ready held 0 for 10 cycles in DONE: out_valid and out_result stable; in_ready = 0 throughout.
// - With MUL_ZERO_BYPASS_EN, MUL a=0, b=5: mul_valid never high, out_valid 2 cycles after accept, result 0.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// =============================================================================
// mul_issue_ctrl
// -----------------------------------------------------------------------------
// RV64M multiply sequencer for the execute stage. It sits between the pipeline
// and the iterative unsigned multiplier core. It:
//   - conditions the operands (absolute value for signed sources, zero
//     extension of the low words for MULW) and remembers whether the final
//     product has to be negated,
//   - launches the core and holds its operands stable until the core reports
//     done,
//   - captures the 128-bit unsigned product, applies the two's-complement
//     sign fix-up and selects the rd value for the opcode,
//   - presents the result on a valid/ready handshake. Only one operation is
//     in flight at a time.
//
// Ports
//   clk         in   1      clock, all state changes on posedge
//   reset       in   1      synchronous active-high reset
//   flush       in   1      pipeline flush, kills any in-flight operation
//   in_valid    in   1      request valid
//   in_ready    out  1      request accepted when high (IDLE and no flush)
//   in_op       in   OP_W   0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal
//   in_a, in_b  in   XLEN   rs1 / rs2 values
//   out_valid   out  1      result valid, held until out_ready
//   out_ready   in   1      consumer accepts the result
//   out_result  out  XLEN   final rd value
//   mul_valid   out  1      core enable, high for the whole core operation
//   mul_a/mul_b out  XLEN   unsigned operands to the core
//   mul_done    in   1      one-cycle pulse, mul_prod valid
//   mul_prod    in   2*XLEN unsigned product from the core
//   busy        out  1      high in every state except IDLE
//
// Build option
//   MUL_ZERO_BYPASS_EN : when defined, an operation whose conditioned operand
//   is zero skips the core and goes straight to the fix-up step with a zero
//   product. When undefined, every legal operation launches the core.
// =============================================================================
module mul_issue_ctrl #(
    parameter int XLEN = 64,
    parameter int OP_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              mul_valid,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    input  logic              mul_done,
    input  logic [2*XLEN-1:0] mul_prod,
    output logic              busy
);

    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MULW   = OP_W'(4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic                neg_q;
    logic [XLEN-1:0]     mul_a_q, mul_b_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN-1:0]     out_result_q;

    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN-1:0]     cond_a, cond_b;
    logic                cond_neg;
    logic                op_legal;
    logic                zero_byp;
    logic                skip_core;
    logic                accept;
    logic [2*XLEN-1:0]   fix_p;
    logic [XLEN-1:0]     sel_result;

    // Handshake and status outputs. Flush masks mul_valid/out_valid in the
    // flush cycle itself, so the core and the consumer see the kill at once.
    assign in_ready   = (state_q == S_IDLE) && !flush;
    assign busy       = (state_q != S_IDLE);
    assign mul_valid  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && !flush;
    assign out_valid  = (state_q == S_DONE) && !flush;
    assign out_result = out_result_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

    assign accept = in_ready && in_valid;

    // The core is unsigned, so signed sources are fed as magnitudes and the
    // sign is reapplied afterwards. The magnitude of the most negative value
    // is 2^(XLEN-1), which still fits as an unsigned operand.
    assign abs_a = in_a[XLEN-1] ? (~in_a + XLEN'(1)) : in_a;
    assign abs_b = in_b[XLEN-1] ? (~in_b + XLEN'(1)) : in_b;

    // Operand conditioning per opcode. Illegal opcodes never reach the core
    // and finish with a zero product.
    always_comb begin
        cond_a   = in_a;
        cond_b   = in_b;
        cond_neg = 1'b0;
        op_legal = 1'b1;
        case (in_op)
            OP_MUL, OP_MULHU: begin
                cond_a = in_a;
                cond_b = in_b;
            end
            OP_MULH: begin
                cond_a   = abs_a;
                cond_b   = abs_b;
                cond_neg = in_a[XLEN-1] ^ in_b[XLEN-1];
            end
            OP_MULHSU: begin
                cond_a   = abs_a;
                cond_neg = in_a[XLEN-1];
            end
            OP_MULW: begin
                cond_a = {{(XLEN-32){1'b0}}, in_a[31:0]};
                cond_b = {{(XLEN-32){1'b0}}, in_b[31:0]};
            end
            default: begin
                cond_a   = '0;
                cond_b   = '0;
                op_legal = 1'b0;
            end
        endcase
    end

`ifdef MUL_ZERO_BYPASS_EN
    // A zero operand makes the product zero, so the core launch is skipped.
    assign zero_byp = (cond_a == '0) || (cond_b == '0);
`else
    assign zero_byp = 1'b0;
`endif

    assign skip_core = !op_legal || zero_byp;

    // Two's-complement negation of the full 128-bit product when the
    // operand signs call for it, then the rd slice for the opcode.
    assign fix_p = neg_q ? (~prod_q + (2*XLEN)'(1)) : prod_q;

    always_comb begin
        sel_result = '0;
        case (op_q)
            OP_MUL:                        sel_result = fix_p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  sel_result = fix_p[2*XLEN-1:XLEN];
            OP_MULW:                       sel_result = {{(XLEN-32){fix_p[31]}}, fix_p[31:0]};
            default:                       sel_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush wins over everything, including a mul_done
    // arriving in the same cycle and an out_ready in DONE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_d = skip_core ? S_FIXUP : S_ISSUE;
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (mul_done) begin
                        state_d = S_FIXUP;
                    end
                end
                S_FIXUP: state_d = S_DONE;
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath registers: operands and sign flag captured at accept, product
    // captured on the core's done pulse (only while waiting for it), result
    // computed once in FIXUP and held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= '0;
            neg_q        <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            prod_q       <= '0;
            out_result_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                neg_q   <= cond_neg;
                mul_a_q <= cond_a;
                mul_b_q <= cond_b;
                if (skip_core) begin
                    prod_q <= '0;
                end
            end
            if ((state_q == S_WAIT) && mul_done && !flush) begin
                prod_q <= mul_prod;
            end
            if ((state_q == S_FIXUP) && !flush) begin
                out_result_q <= sel_result;
            end
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// =============================================================================
// tb_mul_issue_ctrl
// -----------------------------------------------------------------------------
// Scoreboard bench for mul_issue_ctrl. Stimulus pushes the expected rd value
// into a queue when a request is offered; a monitor pops and compares each
// time the DUT hands a result over. Expected values come from a reference
// model using plain signed/unsigned 128-bit arithmetic on the raw operands.
// A small core model answers mul_valid with the product of mul_a and mul_b
// after a programmable latency and throws in stray mul_done pulses while idle.
// =============================================================================
module tb_mul_issue_ctrl;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_MULW   = 3'd4;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    in_op;
   logic [63:0]   in_a;
   logic [63:0]   in_b;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_result;
   logic          mul_valid;
   logic [63:0]   mul_a;
   logic [63:0]   mul_b;
   logic          mul_done;
   logic [127:0]  mul_prod;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   int            coreLat = 3;
   int            coreCnt = 0;
   bit            holdReady = 1'b0;
   logic [63:0]   expQ[$];

   mul_issue_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .mul_valid  (mul_valid),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_done   (mul_done),
      .mul_prod   (mul_prod),
      .busy       (busy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference rd value computed straight from the instruction definitions.
   function automatic logic [63:0] refModel(input logic [2:0] op,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      logic [127:0]        p;
      p = '0;
      case (op)
         OP_MUL: begin
            p = {64'b0, a} * {64'b0, b};
            return p[63:0];
         end
         OP_MULH: begin
            sa = $signed({{64{a[63]}}, a});
            sb = $signed({{64{b[63]}}, b});
            p  = sa * sb;
            return p[127:64];
         end
         OP_MULHSU: begin
            sa = $signed({{64{a[63]}}, a});
            sb = $signed({64'b0, b});
            p  = sa * sb;
            return p[127:64];
         end
         OP_MULHU: begin
            p = {64'b0, a} * {64'b0, b};
            return p[127:64];
         end
         OP_MULW: begin
            p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
            return {{32{p[31]}}, p[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] randOperand();
      logic [63:0] v;
      case ($urandom_range(0, 6))
         0:       v = 64'd0;
         1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         2:       v = 64'h8000_0000_0000_0000;
         3:       v = 64'd1;
         4:       v = {32'hDEAD_BEEF, 32'($urandom)};
         default: v = {32'($urandom), 32'($urandom)};
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   // Offer one request and hold it until in_ready lets it through; the
   // expected value is queued before the accepting edge.
   task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a,
                                input logic [63:0] b, input logic [63:0] expVal,
                                input bit doPush);
      int n;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
            in_valid = 1'b0;
            return;
         end
      end
      if (doPush) expQ.push_back(expVal);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = {32'($urandom), 32'($urandom)};
      in_b     = {32'($urandom), 32'($urandom)};
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", expQ.size());
      end
   endtask

   // Multiplier core model: counts cycles of mul_valid and returns the real
   // product once the count reaches coreLat. Random products appear on the
   // bus otherwise, and occasional stray done pulses while the core is idle.
   initial begin
      mul_done = 1'b0;
      mul_prod = '0;
      forever begin
         @(posedge clk);
         #1;
         mul_done = 1'b0;
         mul_prod = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
         if (mul_valid) begin
            coreCnt++;
            if (coreCnt >= coreLat) begin
               mul_done = 1'b1;
               mul_prod = {64'b0, mul_a} * {64'b0, mul_b};
            end
         end else begin
            coreCnt = 0;
            if ($urandom_range(0, 7) == 0) mul_done = 1'b1;
         end
      end
   end

   // Consumer: random back-pressure unless a test pins out_ready low.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = holdReady ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: a result is handed over when out_valid and out_ready are both
   // high with no flush or reset in that cycle.
   initial begin
      logic [63:0] expVal;
      forever begin
         @(negedge clk);
         if (!reset && !flush && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_result: got 0x%h, expected no output", out_result);
            end else begin
               expVal = expQ.pop_front();
               checkOutput("result", out_result, expVal);
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      int          k;
      bit          sawMulValid;
      bit          sawOutValid;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;

      reset    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_op    = '0;
      in_a     = '0;
      in_b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid",  64'(out_valid), 64'd0);
      checkOutput("rst_mul_valid",  64'(mul_valid), 64'd0);
      checkOutput("rst_busy",       64'(busy),      64'd0);
      checkOutput("rst_in_ready",   64'(in_ready),  64'd1);
      checkOutput("rst_out_result", out_result,     64'd0);
      checkOutput("rst_mul_a",      mul_a,          64'd0);
      checkOutput("rst_mul_b",      mul_b,          64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] directed corner cases");
      applyStimulus(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
      applyStimulus(OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
      applyStimulus(OP_MULH,   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h4000_0000_0000_0000, 1'b1);
      applyStimulus(OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      applyStimulus(OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      applyStimulus(OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      applyStimulus(OP_MULW,   64'hDEAD_BEEF_7FFF_FFFF, 64'hDEAD_BEEF_0000_0002,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      applyStimulus(3'd6,      64'd7, 64'd9, 64'd0, 1'b1);
      waitDrain();

      $display("[TB] zero operand latency");
      coreLat = 4;
      applyStimulus(OP_MUL, 64'd0, 64'd5, 64'd0, 1'b1);
      k = 0;
      sawMulValid = 1'b0;
      do begin
         @(negedge clk);
         k++;
         if (mul_valid) sawMulValid = 1'b1;
      end while (!out_valid && k < 100);
`ifdef MUL_ZERO_BYPASS_EN
      checkOutput("bypass_latency",   64'(k),           64'd2);
      checkOutput("bypass_mul_valid", 64'(sawMulValid), 64'd0);
`else
      // Core answers coreLat-1 cycles after mul_valid rises; three more
      // cycles to out_valid, counted from the accept cycle.
      checkOutput("core_latency",     64'(k),           64'((coreLat - 1) + 3));
      checkOutput("core_mul_valid",   64'(sawMulValid), 64'd1);
`endif
      waitDrain();

      $display("[TB] flush during WAIT");
      coreLat = 20;
      applyStimulus(OP_MUL, 64'd7, 64'd9, 64'd63, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("flush_pre_mul_valid", 64'(mul_valid), 64'd1);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_op    = OP_MUL;
      in_a     = 64'd1;
      in_b     = 64'd1;
      @(negedge clk);
      checkOutput("flush_in_ready",  64'(in_ready),  64'd0);
      checkOutput("flush_mul_valid", 64'(mul_valid), 64'd0);
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("post_flush_busy",      64'(busy),      64'd0);
      checkOutput("post_flush_in_ready",  64'(in_ready),  64'd1);
      checkOutput("post_flush_mul_valid", 64'(mul_valid), 64'd0);
      sawOutValid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) sawOutValid = 1'b1;
      end
      checkOutput("flush_no_out_valid", 64'(sawOutValid), 64'd0);
      coreLat = 3;
      applyStimulus(OP_MUL, 64'd3, 64'd4, 64'd12, 1'b1);
      waitDrain();

      $display("[TB] consumer back-pressure in DONE");
      holdReady = 1'b1;
      repeat (2) @(posedge clk);
      applyStimulus(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput("hold_out_valid",  64'(out_valid), 64'd1);
         checkOutput("hold_out_result", out_result,     64'hFFFF_FFFF_FFFF_FFFE);
         checkOutput("hold_in_ready",   64'(in_ready),  64'd0);
         @(negedge clk);
      end
      holdReady = 1'b0;
      waitDrain();

      $display("[TB] reset during operation");
      coreLat = 10;
      applyStimulus(OP_MUL, 64'd5, 64'd6, 64'd30, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_mul_valid",  64'(mul_valid), 64'd0);
      checkOutput("mid_rst_busy",       64'(busy),      64'd0);
      checkOutput("mid_rst_in_ready",   64'(in_ready),  64'd1);
      checkOutput("mid_rst_out_valid",  64'(out_valid), 64'd0);
      checkOutput("mid_rst_out_result", out_result,     64'd0);
      checkOutput("mid_rst_mul_a",      mul_a,          64'd0);
      checkOutput("mid_rst_mul_b",      mul_b,          64'd0);

      $display("[TB] randomized operations");
      for (int i = 0; i < 250; i++) begin
         op = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
         a  = randOperand();
         b  = randOperand();
         coreLat = $urandom_range(2, 6);
         applyStimulus(op, a, b, refModel(op, a, b), 1'b1);
      end
      waitDrain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
